// File: rtl/text_pixel_gen_if.sv
// Signal bundle between the text pixel generator and its neighbours:
// the sync/timing generator, the text buffer, the font memory and the cursor
// registers.
//   slave  : the pixel generator side. It receives pixel position, sync,
//            character/glyph data and cursor state. It drives the memory
//            addresses and the pixel output.
//   master : the surrounding system, with the directions reversed.
// Port summary:
//   hpos_i, vpos_i       current pixel column / row
//   de_i, hsync_i,       display enable and raw syncs from the timing generator
//   vsync_i
//   text_addr_o, char_i  text-buffer read address / character code (1-cycle read)
//   font_addr_o,         font-memory address {char, glyph_row} / glyph row
//   font_data_i          (1-cycle read); font_data_i bit 0 is the leftmost pixel
//   cursor_*_i           cursor enable and cell position
//   rgb_o, hsync_o,      pixel colour and delayed sync/enable
//   vsync_o, de_o
interface text_pixel_gen_if #(
   parameter int TADDR_W = 13
);
   logic [9:0]         hpos_i;
   logic [9:0]         vpos_i;
   logic               de_i;
   logic               hsync_i;
   logic               vsync_i;
   logic [TADDR_W-1:0] text_addr_o;
   logic [7:0]         char_i;
   logic [10:0]        font_addr_o;
   logic [0:7]         font_data_i;
   logic               cursor_en_i;
   logic [6:0]         cursor_col_i;
   logic [5:0]         cursor_row_i;
   logic [2:0]         rgb_o;
   logic               hsync_o;
   logic               vsync_o;
   logic               de_o;

   modport slave (
      input  hpos_i, vpos_i, de_i, hsync_i, vsync_i,
      input  char_i, font_data_i,
      input  cursor_en_i, cursor_col_i, cursor_row_i,
      output text_addr_o, font_addr_o,
      output rgb_o, hsync_o, vsync_o, de_o
   );

   modport master (
      output hpos_i, vpos_i, de_i, hsync_i, vsync_i,
      output char_i, font_data_i,
      output cursor_en_i, cursor_col_i, cursor_row_i,
      input  text_addr_o, font_addr_o,
      input  rgb_o, hsync_o, vsync_o, de_o
   );
endinterface

// File: rtl/text_pixel_gen.sv
// Text-mode pixel generator. It converts the pixel coordinate into a
// text-buffer address. It then forms the font address from the returned
// character and the glyph row, and picks the glyph bit for the current pixel
// column. A blinking block cursor is XORed over the glyph bit.
// Latency is a fixed 5 cycles from the inputs to rgb/hsync/vsync/de.
// Ports:
//   clk_i  pixel clock
//   rst_i  synchronous active-high reset
//   bus    text_pixel_gen_if.slave. Carries position, sync and cursor inputs,
//          text/font memory address and data, and the delayed pixel outputs.
module text_pixel_gen #(
   parameter int         COLS         = 80,
   parameter int         ROWS         = 60,
   parameter int         TADDR_W      = 13,
   parameter logic [2:0] FG_COLOR     = 3'b111,
   parameter logic [2:0] BG_COLOR     = 3'b000,
   parameter int         BLINK_FRAMES = 32,
   parameter logic       SYNC_ACTIVE  = 1'b0
) (
   input  logic           clk_i,
   input  logic           rst_i,
   text_pixel_gen_if.slave bus
);

   localparam int         CNT_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [6:0] COLS_C = 7'(COLS);
   localparam logic [6:0] ROWS_C = 7'(ROWS);

   // row*COLS + col. For the 80-column mode this is two shifts and an add.
   function automatic logic [TADDR_W-1:0] cell_addr(input logic [6:0] row,
                                                    input logic [6:0] col);
      logic [TADDR_W-1:0] r;
      logic [TADDR_W-1:0] c;
      r = TADDR_W'(row);
      c = TADDR_W'(col);
      if (COLS == 80)
         return (r << 6) + (r << 4) + c;
      else
         return r * TADDR_W'(COLS) + c;
   endfunction

   // Pixels outside the visible area are forced black.
   function automatic logic [2:0] pix_color(input logic de, input logic pix);
      if (!de)
         return 3'b000;
      return pix ? FG_COLOR : BG_COLOR;
   endfunction

   logic [6:0] cell_col;
   logic [6:0] cell_row;
   logic       cell_ok;
   logic       cursor_hit;

   assign cell_col = bus.hpos_i[9:3];
   assign cell_row = bus.vpos_i[9:3];
   // Off-screen coordinates with de high get address 0. Such addresses are
   // don't-care, and this keeps the read inside the buffer.
   assign cell_ok  = bus.de_i && (cell_row < ROWS_C) && (cell_col < COLS_C);
   // The cursor registers are compared unclamped; de_i masks any
   // out-of-range match.
   assign cursor_hit = bus.cursor_en_i && bus.de_i &&
                       (cell_col == bus.cursor_col_i) &&
                       (cell_row == {1'b0, bus.cursor_row_i});

   logic [TADDR_W-1:0] text_addr_p1;
   logic [2:0]         grow_p1, grow_p2;
   logic [2:0]         gcol_p1, gcol_p2, gcol_p3, gcol_p4;
   logic               de_p1, de_p2, de_p3, de_p4, de_p5;
   logic               hs_p1, hs_p2, hs_p3, hs_p4, hs_p5;
   logic               vs_p1, vs_p2, vs_p3, vs_p4, vs_p5;
   logic               hit_p1, hit_p2, hit_p3, hit_p4;
   logic [10:0]        font_addr_p3;
   logic [2:0]         rgb_p5;

   logic               vsync_prev;
   logic [CNT_W-1:0]   blink_cnt;
   logic               blink_phase;
   logic               frame_evt;
   logic               pix;

   assign pix = bus.font_data_i[gcol_p4] ^ (hit_p4 & blink_phase);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         text_addr_p1 <= '0;
         grow_p1      <= '0;
         grow_p2      <= '0;
         gcol_p1      <= '0;
         gcol_p2      <= '0;
         gcol_p3      <= '0;
         gcol_p4      <= '0;
         de_p1        <= 1'b0;
         de_p2        <= 1'b0;
         de_p3        <= 1'b0;
         de_p4        <= 1'b0;
         de_p5        <= 1'b0;
         hs_p1        <= ~SYNC_ACTIVE;
         hs_p2        <= ~SYNC_ACTIVE;
         hs_p3        <= ~SYNC_ACTIVE;
         hs_p4        <= ~SYNC_ACTIVE;
         hs_p5        <= ~SYNC_ACTIVE;
         vs_p1        <= ~SYNC_ACTIVE;
         vs_p2        <= ~SYNC_ACTIVE;
         vs_p3        <= ~SYNC_ACTIVE;
         vs_p4        <= ~SYNC_ACTIVE;
         vs_p5        <= ~SYNC_ACTIVE;
         hit_p1       <= 1'b0;
         hit_p2       <= 1'b0;
         hit_p3       <= 1'b0;
         hit_p4       <= 1'b0;
         font_addr_p3 <= '0;
         rgb_p5       <= 3'b000;
      end else begin
         // stage 1: text-buffer address, sideband capture
         text_addr_p1 <= cell_ok ? cell_addr(cell_row, cell_col) : '0;
         grow_p1      <= bus.vpos_i[2:0];
         gcol_p1      <= bus.hpos_i[2:0];
         de_p1        <= bus.de_i;
         hs_p1        <= bus.hsync_i;
         vs_p1        <= bus.vsync_i;
         hit_p1       <= cursor_hit;
         // stage 2: text buffer returns char_i
         grow_p2      <= grow_p1;
         gcol_p2      <= gcol_p1;
         de_p2        <= de_p1;
         hs_p2        <= hs_p1;
         vs_p2        <= vs_p1;
         hit_p2       <= hit_p1;
         // stage 3: font address
         font_addr_p3 <= {bus.char_i, grow_p2};
         gcol_p3      <= gcol_p2;
         de_p3        <= de_p2;
         hs_p3        <= hs_p2;
         vs_p3        <= vs_p2;
         hit_p3       <= hit_p2;
         // stage 4: font memory returns font_data_i
         gcol_p4      <= gcol_p3;
         de_p4        <= de_p3;
         hs_p4        <= hs_p3;
         vs_p4        <= vs_p3;
         hit_p4       <= hit_p3;
         // stage 5: pixel select and colour
         rgb_p5       <= pix_color(de_p4, pix);
         de_p5        <= de_p4;
         hs_p5        <= hs_p4;
         vs_p5        <= vs_p4;
      end
   end

   // A frame starts when vsync_i enters its active level.
   assign frame_evt = (bus.vsync_i == SYNC_ACTIVE) && (vsync_prev != SYNC_ACTIVE);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vsync_prev  <= ~SYNC_ACTIVE;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else begin
         vsync_prev <= bus.vsync_i;
         if (frame_evt) begin
            if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
               blink_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end
         end
      end
   end

   assign bus.text_addr_o = text_addr_p1;
   assign bus.font_addr_o = font_addr_p3;
   assign bus.rgb_o       = rgb_p5;
   assign bus.de_o        = de_p5;
   assign bus.hsync_o     = hs_p5;
   assign bus.vsync_o     = vs_p5;

endmodule

// File: tb/tb_text_pixel_gen.sv
module tb_text_pixel_gen;
   localparam int TADDR_W = 13;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   text_pixel_gen_if #(.TADDR_W(TADDR_W)) bus ();

   text_pixel_gen #(
      .COLS(80), .ROWS(60), .TADDR_W(TADDR_W),
      .FG_COLOR(3'b111), .BG_COLOR(3'b000),
      .BLINK_FRAMES(32), .SYNC_ACTIVE(1'b0)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   // Text and font memories with 1-cycle synchronous reads.
   // Font bytes are stored MSB = leftmost pixel.
   logic [7:0] text_mem [0:8191];
   logic [7:0] font_mem [0:2047];

   always @(posedge clk) begin
      bus.char_i      <= text_mem[bus.text_addr_o];
      bus.font_data_i <= font_mem[bus.font_addr_o];
   end

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: per-edge history of sampled inputs, and the frame
   // counter / blink phase.
   int  n = 8;
   bit  h_rst [8];
   bit  h_de  [8];
   bit  h_hs  [8];
   bit  h_vs  [8];
   bit  h_cen [8];
   int  h_h   [8];
   int  h_v   [8];
   int  h_cc  [8];
   int  h_cr  [8];
   int  h_ta  [8];
   int  m_cnt = 0;
   bit  m_phase = 1'b0;
   bit  m_prev_vs = 1'b1;

   logic [5:0] exp_out;   // {rgb, de, hsync, vsync}
   int         exp_ta;
   int         exp_fa;

   task automatic drive(input int h, input int v, input bit de, input bit hs, input bit vs);
      bus.hpos_i  = 10'(h);
      bus.vpos_i  = 10'(v);
      bus.de_i    = de;
      bus.hsync_i = hs;
      bus.vsync_i = vs;
   endtask

   task automatic tick();
      int k, j;
      bit valid, hit, fbit, pix, ph_used;
      logic [7:0] ch, glyph;
      @(posedge clk);
      n++;
      k = n % 8;
      h_rst[k] = rst;
      h_de[k]  = bus.de_i;
      h_hs[k]  = bus.hsync_i;
      h_vs[k]  = bus.vsync_i;
      h_h[k]   = int'(bus.hpos_i);
      h_v[k]   = int'(bus.vpos_i);
      h_cen[k] = bus.cursor_en_i;
      h_cc[k]  = int'(bus.cursor_col_i);
      h_cr[k]  = int'(bus.cursor_row_i);
      // blink: the phase seen by the output at this edge is the value before the update
      ph_used = m_phase;
      if (rst) begin
         m_cnt = 0;
         m_phase = 1'b0;
      end else if (!bus.vsync_i && m_prev_vs) begin
         if (m_cnt == 31) begin
            m_cnt = 0;
            m_phase = ~m_phase;
         end else begin
            m_cnt++;
         end
      end
      m_prev_vs = rst ? 1'b1 : bus.vsync_i;
      // text address
      if (rst || !bus.de_i) exp_ta = 0;
      else exp_ta = (h_v[k] / 8) * 80 + h_h[k] / 8;
      h_ta[k] = exp_ta;
      // font address: char for the address issued two edges ago, glyph row from then
      j = (n - 2) % 8;
      if (rst) exp_fa = 0;
      else exp_fa = int'(text_mem[h_ta[j]]) * 8 +
                    ((h_rst[j] || h_rst[(n - 1) % 8]) ? 0 : h_v[j] % 8);
      // pixel outputs: inputs sampled four edges ago, no reset since
      valid = 1'b1;
      for (int i = 0; i < 5; i++) if (h_rst[(n - i) % 8]) valid = 1'b0;
      j = (n - 4) % 8;
      if (!valid) begin
         exp_out = 6'b000_0_1_1;
      end else begin
         pix = 1'b0;
         if (h_de[j]) begin
            hit   = h_cen[j] && (h_h[j] / 8 == h_cc[j]) && (h_v[j] / 8 == h_cr[j]);
            ch    = text_mem[(h_v[j] / 8) * 80 + h_h[j] / 8];
            glyph = font_mem[int'(ch) * 8 + h_v[j] % 8];
            fbit  = glyph[7 - h_h[j] % 8];
            pix   = fbit ^ (hit & ph_used);
         end
         exp_out = {(h_de[j] && pix) ? 3'b111 : 3'b000, h_de[j], h_hs[j], h_vs[j]};
      end
      #1;
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         drive(700, 500, 1'b0, 1'b1, 1'b1);
         tick();
      end
   endtask

   task automatic pump_frames(input int cnt);
      for (int e = 0; e < cnt; e++) begin
         drive(700, 500, 1'b0, 1'b1, 1'b0);
         tick(); tick();
         drive(700, 500, 1'b0, 1'b1, 1'b1);
         tick(); tick();
      end
   endtask

   task automatic test_reset();
      logic [29:0] act;
      rst = 1'b1;
      drive(17, 9, 1'b1, 1'b1, 1'b1);
      for (int t = 0; t < 3; t++) begin
         tick();
         act = {bus.text_addr_o, bus.font_addr_o, bus.rgb_o, bus.de_o, bus.hsync_o, bus.vsync_o};
         n_checks++;
         if (act !== {13'd0, 11'd0, 3'd0, 1'b0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", act, {13'd0, 11'd0, 3'd0, 1'b0, 1'b1, 1'b1});
         end
      end
      rst = 1'b0;
      for (int t = 1; t <= 5; t++) begin
         tick();
         n_checks++;
         if (bus.de_o !== (t == 5)) begin
            n_fail++;
            $display("FAIL reset_release_de t=%0d: got %b want %b", t, bus.de_o, (t == 5));
         end
         n_checks++;
         if ({bus.rgb_o, bus.de_o, bus.hsync_o, bus.vsync_o} !== exp_out) begin
            n_fail++;
            $display("FAIL reset_release_out t=%0d: got %b want %b", t,
                     {bus.rgb_o, bus.de_o, bus.hsync_o, bus.vsync_o}, exp_out);
         end
      end
   endtask

   task automatic test_addr_path();
      text_mem[82] = 8'h41;
      font_mem[11'h209] = 8'b0100_0000;
      for (int pass = 0; pass < 2; pass++) begin
         idle(6);
         drive(pass ? 16 : 17, 9, 1'b1, 1'b1, 1'b1);
         tick();
         n_checks++;
         if (bus.text_addr_o !== 13'd82) begin
            n_fail++;
            $display("FAIL addr_text pass=%0d: got %0d want 82", pass, bus.text_addr_o);
         end
         drive(700, 500, 1'b0, 1'b1, 1'b1);
         tick(); tick();
         n_checks++;
         if (bus.font_addr_o !== 11'h209) begin
            n_fail++;
            $display("FAIL addr_font pass=%0d: got %h want 209", pass, bus.font_addr_o);
         end
         tick(); tick();
         n_checks++;
         if ({bus.rgb_o, bus.de_o} !== {(pass ? 3'b000 : 3'b111), 1'b1}) begin
            n_fail++;
            $display("FAIL addr_rgb pass=%0d: got %b want %b", pass, {bus.rgb_o, bus.de_o},
                     {(pass ? 3'b000 : 3'b111), 1'b1});
         end
         n_checks++;
         if ({bus.rgb_o, bus.de_o, bus.hsync_o, bus.vsync_o} !== exp_out) begin
            n_fail++;
            $display("FAIL addr_model pass=%0d: got %b want %b", pass,
                     {bus.rgb_o, bus.de_o, bus.hsync_o, bus.vsync_o}, exp_out);
         end
      end
   endtask

   task automatic test_last_cell();
      text_mem[4799] = 8'hFF;
      for (int pass = 0; pass < 2; pass++) begin
         font_mem[11'h7FF] = pass ? 8'b1111_1110 : 8'b0000_0001;
         idle(6);
         drive(639, 479, 1'b1, 1'b1, 1'b1);
         tick();
         n_checks++;
         if (bus.text_addr_o !== 13'd4799) begin
            n_fail++;
            $display("FAIL last_text pass=%0d: got %0d want 4799", pass, bus.text_addr_o);
         end
         drive(700, 500, 1'b0, 1'b1, 1'b1);
         tick(); tick();
         n_checks++;
         if (bus.font_addr_o !== 11'h7FF) begin
            n_fail++;
            $display("FAIL last_font pass=%0d: got %h want 7ff", pass, bus.font_addr_o);
         end
         tick(); tick();
         n_checks++;
         if (bus.rgb_o !== (pass ? 3'b000 : 3'b111)) begin
            n_fail++;
            $display("FAIL last_rgb pass=%0d: got %b want %b", pass, bus.rgb_o, (pass ? 3'b000 : 3'b111));
         end
      end
   endtask

   task automatic test_sync_blank();
      bit exp_h;
      for (int t = 0; t < 110; t++) begin
         drive(640 + t, $urandom_range(0, 479), 1'b0, !(t >= 5 && t < 101), 1'b1);
         tick();
         exp_h = !((t - 4) >= 5 && (t - 4) < 101);
         n_checks++;
         if ({bus.hsync_o, bus.rgb_o} !== {exp_h, 3'b000}) begin
            n_fail++;
            $display("FAIL sync_blank t=%0d: got hs=%b rgb=%b want hs=%b rgb=000", t, bus.hsync_o, bus.rgb_o, exp_h);
         end
         n_checks++;
         if ({bus.rgb_o, bus.de_o, bus.hsync_o, bus.vsync_o} !== exp_out) begin
            n_fail++;
            $display("FAIL sync_model t=%0d: got %b want %b", t,
                     {bus.rgb_o, bus.de_o, bus.hsync_o, bus.vsync_o}, exp_out);
         end
      end
   endtask

   task automatic test_cursor_blink();
      logic [2:0] want;
      text_mem[82] = 8'h41;
      text_mem[83] = 8'h41;
      font_mem[11'h209] = 8'h00;
      bus.cursor_en_i  = 1'b1;
      bus.cursor_col_i = 7'd2;
      bus.cursor_row_i = 6'd1;
      rst = 1'b1;
      drive(17, 9, 1'b1, 1'b1, 1'b1);
      tick(); tick();
      rst = 1'b0;
      for (int e = 1; e <= 64; e++) begin
         drive(17, 9, 1'b1, 1'b1, 1'b0);
         tick(); tick();
         drive(17, 9, 1'b1, 1'b1, 1'b1);
         tick(); tick();
         want = (e >= 32 && e < 64) ? 3'b111 : 3'b000;
         n_checks++;
         if (bus.rgb_o !== want) begin
            n_fail++;
            $display("FAIL cursor_blink e=%0d: got %b want %b", e, bus.rgb_o, want);
         end
         n_checks++;
         if ({bus.rgb_o, bus.de_o, bus.hsync_o, bus.vsync_o} !== exp_out) begin
            n_fail++;
            $display("FAIL cursor_model e=%0d: got %b want %b", e,
                     {bus.rgb_o, bus.de_o, bus.hsync_o, bus.vsync_o}, exp_out);
         end
         if (e == 40) begin
            drive(25, 9, 1'b1, 1'b1, 1'b1);
            repeat (5) tick();
            n_checks++;
            if (bus.rgb_o !== 3'b000) begin
               n_fail++;
               $display("FAIL cursor_other_cell: got %b want 000", bus.rgb_o);
            end
            drive(17, 9, 1'b1, 1'b1, 1'b1);
            repeat (5) tick();
         end
      end
      bus.cursor_en_i = 1'b0;
   endtask

   task automatic test_mid_reset();
      for (int t = 0; t < 30; t++) begin
         rst = (t == 12 || t == 13);
         drive($urandom_range(0, 639), $urandom_range(0, 479), 1'b1, 1'($urandom_range(0, 1)), 1'b1);
         tick();
         n_checks++;
         if ({bus.rgb_o, bus.de_o, bus.hsync_o, bus.vsync_o} !== exp_out) begin
            n_fail++;
            $display("FAIL midreset_model t=%0d: got %b want %b", t,
                     {bus.rgb_o, bus.de_o, bus.hsync_o, bus.vsync_o}, exp_out);
         end
         if (t >= 12 && t <= 18) begin
            n_checks++;
            if (bus.de_o !== (t == 18)) begin
               n_fail++;
               $display("FAIL midreset_de t=%0d: got %b want %b", t, bus.de_o, (t == 18));
            end
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_stream();
      int lines [20];
      int crow;
      for (int i = 0; i < 4800; i++) text_mem[i] = 8'($urandom);
      for (int i = 0; i < 2048; i++) font_mem[i] = 8'($urandom);
      crow = $urandom_range(0, 59);
      bus.cursor_en_i  = 1'b1;
      bus.cursor_col_i = 7'($urandom_range(0, 79));
      bus.cursor_row_i = 6'(crow);
      lines[0] = 0;
      lines[1] = 479;
      lines[2] = crow * 8 + $urandom_range(0, 7);
      lines[10] = crow * 8 + $urandom_range(0, 7);
      for (int i = 3; i < 20; i++) if (i != 10) lines[i] = $urandom_range(0, 479);
      pump_frames(32);
      for (int l = 0; l < 20; l++) begin
         if (l == 10) begin
            pump_frames(32);
            bus.cursor_col_i = 7'($urandom_range(0, 127));
            if (l == 10) bus.cursor_col_i = 7'($urandom_range(0, 79));
         end
         if (l == 15) bus.cursor_col_i = 7'($urandom_range(80, 127));
         for (int h = 0; h < 800; h++) begin
            drive(h, lines[l], h < 640, !(h >= 656 && h < 752), 1'b1);
            tick();
            n_checks++;
            if ({bus.rgb_o, bus.de_o, bus.hsync_o, bus.vsync_o} !== exp_out) begin
               n_fail++;
               $display("FAIL stream_out v=%0d h=%0d: got %b want %b", lines[l], h,
                        {bus.rgb_o, bus.de_o, bus.hsync_o, bus.vsync_o}, exp_out);
            end
            n_checks++;
            if ({bus.text_addr_o, bus.font_addr_o} !== {13'(exp_ta), 11'(exp_fa)}) begin
               n_fail++;
               $display("FAIL stream_addr v=%0d h=%0d: got ta=%0d fa=%h want ta=%0d fa=%h",
                        lines[l], h, bus.text_addr_o, bus.font_addr_o, exp_ta, exp_fa);
            end
         end
      end
      bus.cursor_en_i = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         h_rst[i] = 1'b1; h_de[i] = 1'b0; h_hs[i] = 1'b1; h_vs[i] = 1'b1; h_cen[i] = 1'b0;
         h_h[i] = 0; h_v[i] = 0; h_cc[i] = 0; h_cr[i] = 0; h_ta[i] = 0;
      end
      for (int i = 0; i < 8192; i++) text_mem[i] = 8'($urandom);
      for (int i = 0; i < 2048; i++) font_mem[i] = 8'($urandom);
      rst = 1'b1;
      bus.cursor_en_i  = 1'b0;
      bus.cursor_col_i = 7'd0;
      bus.cursor_row_i = 6'd0;
      drive(0, 0, 1'b0, 1'b1, 1'b1);

      test_reset();
      test_addr_path();
      test_last_cell();
      test_sync_blank();
      test_cursor_blink();
      test_mid_reset();
      test_stream();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
